// File: rtl/active_index_queue.sv
// active_index_queue
//   Scans a binary pixel frame LANES pixels per beat and compacts the index of
//   every set pixel into one of two ping-pong banks. One bank fills from the
//   scan while the other drains to the consumer over a valid/ready handshake.
//
// Ports:
//   clk         in   clock, all logic on the rising edge
//   resetQueue  in   synchronous active-high reset
//   pixelValid  in   pixelBits beat valid
//   pixelBits   in   [LANES]  bit k = pixel (scanIndex+k)
//   pixelReady  out  fill side accepts a beat
//   frameDone   out  one-cycle pulse when a filled bank is handed to the drain side
//   overflow    out  sticky: a set pixel was dropped because the bank was full
//   indexValid  out  indexOut holds a queued index
//   indexOut    out  [IDX_W] front entry of the drain bank
//   indexLast   out  indexOut is the final entry of the frame
//   indexReady  in   consumer accepts indexOut
//   queueEmpty  out  drain side idle, nothing pending
module active_index_queue #(
  parameter int NUM_INPUTS = 784,
  parameter int LANES      = 4,
  parameter int DEPTH      = 784,
  parameter int IDX_W      = 10
) (
  input  logic             clk,
  input  logic             resetQueue,
  input  logic             pixelValid,
  input  logic [LANES-1:0] pixelBits,
  output logic             pixelReady,
  output logic             frameDone,
  output logic             overflow,
  output logic             indexValid,
  output logic [IDX_W-1:0] indexOut,
  output logic             indexLast,
  input  logic             indexReady,
  output logic             queueEmpty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(NUM_INPUTS + LANES + 1);

  typedef enum logic { SCAN, COMMIT } fill_state_t;
  typedef enum logic { IDLE, ACTIVE } drain_state_t;

  fill_state_t  fill_state, fill_next;
  drain_state_t drain_state, drain_next;

  logic [IDX_W-1:0] bank [2][DEPTH];

  logic          fill_sel;
  logic          drain_sel;
  logic [CW-1:0] fill_count;
  logic [CW-1:0] drain_len;
  logic [CW-1:0] rd_ptr;
  logic [SW-1:0] scan_index;
  logic          frame_done_r;
  logic          overflow_r;

  logic beat_accept;
  logic last_beat;
  logic swap;
  logic out_accept;
  logic at_last;

  logic [LANES-1:0] wr_en;
  logic [AW-1:0]    wr_addr [LANES];
  logic [IDX_W-1:0] wr_data [LANES];
  logic             drop;
  logic [CW-1:0]    count_next;
  int unsigned      hit_cnt;
  int unsigned      pos;

  assign beat_accept = pixelValid && pixelReady;
  assign last_beat   = (32'(scan_index) + LANES >= NUM_INPUTS);
  // Swap only against a registered IDLE drain side, so a frame that just
  // finished draining always leaves one idle cycle before the next handover.
  assign swap        = (fill_state == COMMIT) && (drain_state == IDLE);
  assign out_accept  = indexValid && indexReady;
  assign at_last     = (rd_ptr == drain_len - CW'(1));

  // Lane compaction: each hit lands at fillCount plus the hits in lower lanes.
  always_comb begin
    wr_en   = '0;
    drop    = 1'b0;
    hit_cnt = 0;
    pos     = 0;
    for (int unsigned k = 0; k < LANES; k++) begin
      wr_addr[k] = '0;
      wr_data[k] = IDX_W'(32'(scan_index) + k);
      if (beat_accept && pixelBits[k] && (32'(scan_index) + k < NUM_INPUTS)) begin
        pos = 32'(fill_count) + hit_cnt;
        if (pos < DEPTH) begin
          wr_en[k]   = 1'b1;
          wr_addr[k] = AW'(pos);
        end else begin
          drop = 1'b1;
        end
        hit_cnt = hit_cnt + 1;
      end
    end
    if (32'(fill_count) + hit_cnt >= DEPTH) begin
      count_next = CW'(DEPTH);
    end else begin
      count_next = CW'(32'(fill_count) + hit_cnt);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (resetQueue) begin
      fill_state  <= SCAN;
      drain_state <= IDLE;
    end else begin
      fill_state  <= fill_next;
      drain_state <= drain_next;
    end
  end

  // Next-state logic
  always_comb begin
    fill_next  = fill_state;
    drain_next = drain_state;
    case (fill_state)
      SCAN:    if (beat_accept && last_beat) fill_next = COMMIT;
      COMMIT:  if (drain_state == IDLE) fill_next = SCAN;
      default: fill_next = SCAN;
    endcase
    case (drain_state)
      IDLE:    if (swap && (fill_count != '0)) drain_next = ACTIVE;
      ACTIVE:  if (out_accept && at_last) drain_next = IDLE;
      default: drain_next = IDLE;
    endcase
  end

  // Outputs; reset forces the idle values even before the first edge.
  always_comb begin
    pixelReady = !resetQueue && (fill_state == SCAN);
    indexValid = !resetQueue && (drain_state == ACTIVE);
    queueEmpty = !indexValid;
    indexOut   = indexValid ? bank[drain_sel][AW'(rd_ptr)] : '0;
    indexLast  = indexValid && at_last;
    frameDone  = !resetQueue && frame_done_r;
    overflow   = !resetQueue && overflow_r;
  end

  // Control datapath
  always_ff @(posedge clk) begin
    if (resetQueue) begin
      fill_sel     <= 1'b0;
      drain_sel    <= 1'b0;
      fill_count   <= '0;
      drain_len    <= '0;
      rd_ptr       <= '0;
      scan_index   <= '0;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      frame_done_r <= swap;
      if (drop) overflow_r <= 1'b1;
      if (swap) begin
        drain_sel  <= fill_sel;
        drain_len  <= fill_count;
        rd_ptr     <= '0;
        fill_sel   <= ~fill_sel;
        fill_count <= '0;
        scan_index <= '0;
      end else begin
        if (beat_accept) begin
          fill_count <= count_next;
          scan_index <= scan_index + SW'(LANES);
        end
        if (out_accept) rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  // Bank storage, no reset: occupancy is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wr_en[k]) bank[fill_sel][wr_addr[k]] <= wr_data[k];
    end
  end

endmodule

// File: tb/tb_active_index_queue.sv
module tb_active_index_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: 10 px / 4 lanes / depth 10; 1: depth 3; 2: 784 px / 1 lane
  logic       rst    [3];
  logic       pv     [3];
  logic       irdy   [3];
  logic       pready [3];
  logic       fd     [3];
  logic       ovf    [3];
  logic       iv     [3];
  logic       il     [3];
  logic       qe     [3];
  logic [3:0] bits   [3];
  logic [9:0] io     [3];

  active_index_queue #(.NUM_INPUTS(10), .LANES(4), .DEPTH(10), .IDX_W(10)) u_a (
    .clk(clk), .resetQueue(rst[0]), .pixelValid(pv[0]), .pixelBits(bits[0]),
    .pixelReady(pready[0]), .frameDone(fd[0]), .overflow(ovf[0]), .indexValid(iv[0]),
    .indexOut(io[0]), .indexLast(il[0]), .indexReady(irdy[0]), .queueEmpty(qe[0]));

  active_index_queue #(.NUM_INPUTS(10), .LANES(4), .DEPTH(3), .IDX_W(10)) u_b (
    .clk(clk), .resetQueue(rst[1]), .pixelValid(pv[1]), .pixelBits(bits[1]),
    .pixelReady(pready[1]), .frameDone(fd[1]), .overflow(ovf[1]), .indexValid(iv[1]),
    .indexOut(io[1]), .indexLast(il[1]), .indexReady(irdy[1]), .queueEmpty(qe[1]));

  active_index_queue #(.NUM_INPUTS(784), .LANES(1), .DEPTH(784), .IDX_W(10)) u_c (
    .clk(clk), .resetQueue(rst[2]), .pixelValid(pv[2]), .pixelBits(bits[2][0:0]),
    .pixelReady(pready[2]), .frameDone(fd[2]), .overflow(ovf[2]), .indexValid(iv[2]),
    .indexOut(io[2]), .indexLast(il[2]), .indexReady(irdy[2]), .queueEmpty(qe[2]));

  int checks = 0;
  int errors = 0;

  int   got    [$];
  logic gotl   [$];
  int   exp_q  [$];
  logic expl_q [$];
  int   fdn;
  int   fd_at;

  typedef struct {
    logic       r, v;
    logic [3:0] b;
    logic       rd;
    logic       e_prdy, e_fd, e_iv;
    logic [9:0] e_io;
    logic       e_il, e_qe, e_ovf;
  } vec_t;

  vec_t tbl [16];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input logic [3:0] b);
    pv[d]   = 1'b1;
    bits[d] = b;
    #1;
    chk("beat_ready", pready[d], 1);
    tick();
    pv[d] = 1'b0;
  endtask

  // Free-running drain with indexReady=1 for n cycles, recording the stream.
  task automatic run(input int d, input int n);
    got.delete();
    gotl.delete();
    fdn     = 0;
    fd_at   = -1;
    pv[d]   = 1'b0;
    irdy[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (fd[d]) begin
        fdn++;
        if (fd_at < 0) fd_at = i;
      end
      if (iv[d]) begin
        got.push_back(int'(io[d]));
        gotl.push_back(il[d]);
      end
      tick();
    end
  endtask

  task automatic check_stream(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk({name, "_idx"}, got[i], exp_q[i]);
      chk({name, "_last"}, gotl[i], expl_q[i]);
    end
  endtask

  initial begin
    // r v b rd | prdy fd iv io il qe ovf
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd8, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd9, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    // all-zero frame, upper lanes of the last beat set but out of range
    tbl[10] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; pv[d] = 1'b0; irdy[d] = 1'b0; bits[d] = 4'h0;
    end
    tick();
    rst[1] = 1'b0;
    rst[2] = 1'b0;

    // ---- table: basic frame then all-zero frame on u_a
    for (int i = 0; i < 16; i++) begin
      rst[0] = tbl[i].r; pv[0] = tbl[i].v; bits[0] = tbl[i].b; irdy[0] = tbl[i].rd;
      #1;
      chk("tbl_pready", pready[0], tbl[i].e_prdy);
      chk("tbl_fdone",  fd[0],     tbl[i].e_fd);
      chk("tbl_ivalid", iv[0],     tbl[i].e_iv);
      chk("tbl_iout",   io[0],     tbl[i].e_io);
      chk("tbl_ilast",  il[0],     tbl[i].e_il);
      chk("tbl_qempty", qe[0],     tbl[i].e_qe);
      chk("tbl_ovf",    ovf[0],    tbl[i].e_ovf);
      tick();
    end
    pv[0] = 1'b0;

    // ---- back-pressure: frame A held, frame B stalls in commit
    irdy[0] = 1'b0;
    repeat (3) beat(0, 4'hF);
    #1; chk("bp_commit_ready", pready[0], 0); tick();
    pv[0] = 1'b1; bits[0] = 4'hF;
    #1;
    chk("bp_fd", fd[0], 1); chk("bp_iv", iv[0], 1); chk("bp_io", io[0], 0);
    chk("bp_b_ready", pready[0], 1);
    tick();
    pv[0] = 1'b0;
    repeat (2) beat(0, 4'hF);
    repeat (5) begin
      #1;
      chk("bp_stall_ready", pready[0], 0); chk("bp_stall_iv", iv[0], 1);
      chk("bp_stall_io", io[0], 0); chk("bp_stall_fd", fd[0], 0);
      tick();
    end
    irdy[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      #1;
      chk("bpA_iv", iv[0], 1); chk("bpA_io", io[0], j);
      chk("bpA_last", il[0], (j == 9)); chk("bpA_fd", fd[0], 0);
      tick();
    end
    #1;
    chk("bp_gap_iv", iv[0], 0); chk("bp_gap_fd", fd[0], 0);
    chk("bp_gap_qe", qe[0], 1); chk("bp_gap_ready", pready[0], 0);
    tick();
    for (int j = 0; j < 10; j++) begin
      #1;
      chk("bpB_iv", iv[0], 1); chk("bpB_io", io[0], j);
      chk("bpB_last", il[0], (j == 9)); chk("bpB_fd", fd[0], (j == 0));
      tick();
    end
    #1; chk("bp_end_iv", iv[0], 0); chk("bp_end_qe", qe[0], 1); tick();

    // ---- reset mid-drain, then frame 1000000001
    repeat (3) beat(0, 4'hF);
    #1; chk("rst_commit", pready[0], 0); tick();
    #1; chk("rst_io0", io[0], 0); tick();
    #1; chk("rst_io1", io[0], 1); tick();
    rst[0] = 1'b1;
    #1; chk("rst_during_iv", iv[0], 0); chk("rst_during_qe", qe[0], 1);
    chk("rst_during_ready", pready[0], 0); tick();
    rst[0] = 1'b0;
    #1; chk("rst_after_iv", iv[0], 0); chk("rst_after_qe", qe[0], 1);
    chk("rst_after_fd", fd[0], 0); chk("rst_after_ready", pready[0], 1); tick();
    beat(0, 4'b0001); beat(0, 4'b0000); beat(0, 4'b0010);
    run(0, 8);
    exp_q = '{0, 9}; expl_q = '{1'b0, 1'b1};
    check_stream("rst_frame");
    chk("rst_frame_fd", fdn, 1);

    // ---- overflow with DEPTH=3
    repeat (3) beat(1, 4'hF);
    run(1, 8);
    exp_q = '{0, 1, 2}; expl_q = '{1'b0, 1'b0, 1'b1};
    check_stream("ovf_frame");
    chk("ovf_sticky", ovf[1], 1);
    rst[1] = 1'b1;
    #1; chk("ovf_in_reset", ovf[1], 0); tick();
    rst[1] = 1'b0;
    #1; chk("ovf_cleared", ovf[1], 0); chk("ovf_qe", qe[1], 1); tick();

    // ---- LANES=1, 784 pixels, pixels 3 and 783
    for (int p = 0; p < 784; p++) beat(2, {3'b000, (p == 3 || p == 783)});
    run(2, 6);
    exp_q = '{3, 783}; expl_q = '{1'b0, 1'b1};
    check_stream("lane1");
    chk("lane1_fd_latency", fd_at, 1);
    chk("lane1_fd_count", fdn, 1);

    // ---- randomized frames on u_a against a list model
    begin
      logic [9:0] fr [6];
      int   beat_ptr;
      int   f, b, p;
      logic prev_hold, acc, done;
      logic [9:0] prev_io;
      logic prev_il;
      fr[0] = 10'h000;
      fr[1] = 10'h3FF;
      for (int i = 2; i < 6; i++) fr[i] = 10'($urandom());
      exp_q.delete(); expl_q.delete();
      for (int i = 0; i < 6; i++) begin
        for (int q = 0; q < 10; q++) begin
          if (fr[i][q]) begin
            exp_q.push_back(q);
            expl_q.push_back(fr[i] >> (q + 1) == 0);
          end
        end
      end
      beat_ptr = 0; fdn = 0; prev_hold = 1'b0; prev_io = '0; prev_il = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
        if (beat_ptr < 18) begin
          f = beat_ptr / 3;
          b = beat_ptr % 3;
          for (int k = 0; k < 4; k++) begin
            p = b * 4 + k;
            bits[0][k] = (p < 10) ? fr[f][p] : 1'($urandom_range(0, 1));
          end
          pv[0] = ($urandom_range(0, 3) != 0);
        end else begin
          pv[0] = 1'b0;
        end
        irdy[0] = 1'($urandom_range(0, 1));
        #1;
        if (prev_hold) begin
          chk("rand_hold_io", io[0], prev_io);
          chk("rand_hold_last", il[0], prev_il);
        end
        if (fd[0]) fdn++;
        if (iv[0] && irdy[0]) begin
          if (exp_q.size() == 0) begin
            chk("rand_extra", 1, 0);
          end else begin
            chk("rand_idx", io[0], exp_q.pop_front());
            chk("rand_last", il[0], expl_q.pop_front());
          end
        end
        prev_hold = iv[0] && !irdy[0];
        prev_io   = io[0];
        prev_il   = il[0];
        acc       = pv[0] && pready[0];
        tick();
        if (acc) beat_ptr++;
        done = (beat_ptr == 18) && (exp_q.size() == 0) && (fdn == 6);
      end
      pv[0] = 1'b0;
      chk("rand_done", done, 1);
      chk("rand_left", exp_q.size(), 0);
      chk("rand_fd_count", fdn, 6);
      chk("rand_ovf", ovf[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
